hilo_mul_unit: RTL
==================

HILO_MUL_UNIT -- requirements
Module: hilo_mul_unit

Interface
REQ-001 Parameter MUL_MADD, default 3'b000, mul_op code for signed multiply-accumulate into HI:LO.
REQ-002 Parameter MUL_MADDU, default 3'b001, mul_op code for unsigned multiply-accumulate into HI:LO.
REQ-003 Parameter MUL_MUL, default 3'b010, mul_op code for signed multiply overwriting HI:LO.
REQ-004 Parameter MUL_MFHI, default 3'b101, mul_op code selecting HI on rd_data.
REQ-005 Parameter MUL_MFLO, default 3'b100, mul_op code selecting LO on rd_data.
REQ-006 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 Port rst_n, input, 1, reset; asynchronous and active-low.
REQ-008 Port start, input, 1, request to launch the operation on mul_op/src_a/src_b.
REQ-009 Port mul_op, input, 3, operation code from the instruction decoder.
REQ-010 Port src_a, input, 32, first operand (rs).
REQ-011 Port src_b, input, 32, second operand (rt).
REQ-012 Port flush, input, 1, synchronous abort of an in-flight operation.
REQ-013 Port busy, output, 1, operation in flight; the pipeline stalls HI/LO users while it is high.
REQ-014 Port done, output, 1, one-cycle pulse: HI/LO hold the new result.
REQ-015 Port hi, output, 32, current HI register.
REQ-016 Port lo, output, 32, current LO register.
REQ-017 Port rd_data, output, 32, hi when mul_op==MUL_MFHI, else lo (combinational).

Function
REQ-018 The FSM SHALL have states IDLE, CALC and DONE; busy SHALL equal (state!=IDLE); done SHALL equal (state==DONE).
REQ-019 In IDLE, start=1 with mul_op in {MUL_MADD, MUL_MADDU, MUL_MUL} SHALL latch the operands and op and enter CALC; any other mul_op SHALL leave the FSM in IDLE.
REQ-020 start SHALL be ignored in CALC and DONE; operands latched at acceptance SHALL be used even if the inputs change afterwards.
REQ-021 CALC SHALL perform a shift-add multiply of the operand magnitudes over exactly 32 cycles, with the signed ops negating the 64-bit product when the operand signs differ.
REQ-022 On the edge leaving CALC, HI:LO SHALL be loaded with the product (MUL_MUL), HI:LO+signed product (MUL_MADD) or HI:LO+unsigned product (MUL_MADDU), modulo 2^64, and the FSM SHALL enter DONE.
REQ-023 DONE SHALL last one cycle and then return to IDLE; a start in that IDLE cycle SHALL be accepted normally.
REQ-024 With acceptance in cycle T, busy SHALL be high in cycles T+1..T+33, done high in T+33 only, and the new HI/LO SHALL be visible from T+33.
REQ-025 flush=1 in CALC SHALL return the FSM to IDLE on the next edge, leave HI/LO unchanged and suppress done; flush in IDLE or DONE SHALL have no effect.
REQ-026 hi, lo and rd_data SHALL always reflect the current registers, including while busy.

Reset
REQ-027 rst_n low SHALL asynchronously force state=IDLE, HI=0, LO=0, the operand/accumulator registers=0, busy=0, done=0, including in the middle of an operation.
REQ-028 The first start after rst_n rises SHALL be accepted on the first rising edge at which it is sampled.

Configuration
REQ-029 With macro MUL_FAST_EN defined, CALC SHALL last one cycle using a single-cycle 32x32 multiplier, giving busy T+1..T+2 and done at T+2; without it, the 32-cycle iterative datapath of REQ-021 SHALL be built.
REQ-030 Results, flush and reset behaviour SHALL be identical with and without MUL_FAST_EN.

Verification
REQ-031 HI:LO=0, MUL_MUL, src_a=3, src_b=0xFFFFFFFB -> done at T+33, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-032 HI:LO=0, MUL_MADDU, src_a=src_b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
REQ-033 HI:LO=0x7FFFFFFF_FFFFFFFF, MUL_MADD, src_a=src_b=1 -> hi=0x80000000, lo=0x00000000; then mul_op=MUL_MFHI -> rd_data=0x80000000.
REQ-034 MUL_MUL accepted, flush at T+10 -> busy low from T+11, done never pulses, HI/LO unchanged; a second start during T+1..T+10 is ignored.
REQ-035 rst_n pulsed low at T+20 of a MADD -> immediately busy=0, hi=lo=0; after release a MUL of 2*2 yields hi=0, lo=4.

Source files
------------

// File: rtl/hilo_mul_unit.sv
// HI/LO multiply / multiply-accumulate unit: iterative 32-cycle shift-add by default.
// Define MUL_FAST_EN to build a single-cycle 32x32 multiplier instead (CALC lasts one cycle).
module hilo_mul_unit #(
    parameter logic [2:0] MUL_MADD  = 3'b000,
    parameter logic [2:0] MUL_MADDU = 3'b001,
    parameter logic [2:0] MUL_MUL   = 3'b010,
    parameter logic [2:0] MUL_MFHI  = 3'b101,
    parameter logic [2:0] MUL_MFLO  = 3'b100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  mul_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q, state_d;
    logic [2:0]  op_q;
    logic        neg_q;
    logic [31:0] hi_q, lo_q;

    logic        op_valid;
    logic        accept;
    logic        calc_last;
    logic        signed_in;
    logic [31:0] mag_a_in, mag_b_in;
    logic [63:0] prod_mag;
    logic [63:0] prod;
    logic [63:0] result;

`ifdef MUL_FAST_EN
    logic [31:0] opa_q, opb_q;
`else
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [63:0] acc_q;
    logic [4:0]  count_q;
`endif

    assign op_valid  = (mul_op == MUL_MADD) || (mul_op == MUL_MADDU) || (mul_op == MUL_MUL);
    assign accept    = (state_q == StIdle) && start && op_valid;
    assign signed_in = (mul_op != MUL_MADDU);
    // Magnitudes; -0x80000000 wraps to 0x80000000, which is the correct unsigned magnitude.
    assign mag_a_in  = (signed_in && src_a[31]) ? (~src_a + 32'd1) : src_a;
    assign mag_b_in  = (signed_in && src_b[31]) ? (~src_b + 32'd1) : src_b;

`ifdef MUL_FAST_EN
    assign calc_last = 1'b1;
    assign prod_mag  = {32'd0, opa_q} * {32'd0, opb_q};
`else
    assign calc_last = (count_q == 5'd31);
    // Accumulator including this cycle's partial product, so the last step is folded in.
    assign prod_mag  = acc_q + (mplier_q[0] ? mcand_q : 64'd0);
`endif

    always_comb begin
        prod = neg_q ? (~prod_mag + 64'd1) : prod_mag;
        if (op_q == MUL_MUL) begin
            result = prod;
        end else begin
            result = {hi_q, lo_q} + prod;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) state_d = StCalc;
            end
            StCalc: begin
                if (flush) begin
                    state_d = StIdle;
                end else if (calc_last) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy = (state_q != StIdle);
        done = (state_q == StDone);
    end

    // Operand latch and iterative datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q     <= 3'd0;
            neg_q    <= 1'b0;
`ifdef MUL_FAST_EN
            opa_q    <= 32'd0;
            opb_q    <= 32'd0;
`else
            mcand_q  <= 64'd0;
            mplier_q <= 32'd0;
            acc_q    <= 64'd0;
            count_q  <= 5'd0;
`endif
        end else if (accept) begin
            op_q     <= mul_op;
            neg_q    <= signed_in && (src_a[31] ^ src_b[31]);
`ifdef MUL_FAST_EN
            opa_q    <= mag_a_in;
            opb_q    <= mag_b_in;
`else
            mcand_q  <= {32'd0, mag_a_in};
            mplier_q <= mag_b_in;
            acc_q    <= 64'd0;
            count_q  <= 5'd0;
`endif
        end else if (state_q == StCalc) begin
`ifndef MUL_FAST_EN
            acc_q    <= prod_mag;
            mcand_q  <= {mcand_q[62:0], 1'b0};
            mplier_q <= {1'b0, mplier_q[31:1]};
            count_q  <= count_q + 5'd1;
`endif
        end
    end

    // HI/LO write on the edge leaving CALC, unless aborted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if ((state_q == StCalc) && !flush && calc_last) begin
            hi_q <= result[63:32];
            lo_q <= result[31:0];
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rd_data = (mul_op == MUL_MFHI) ? hi_q : lo_q;

endmodule
